// File: rtl/rc4_ctrl_if.sv
// Bus bundle for rc4_ctrl: key fetch, S-memory read/swap port and keystream output.
// Keystream handshake: a byte transfers on any clk edge where ks_valid=1 and ks_ready=1; ks_data is stable while ks_valid=1 and ks_ready=0.
interface rc4_ctrl_if;
  logic [7:0] key_addr;
  logic [7:0] key_byte;
  logic       S_swap;
  logic [7:0] S_addr_a;
  logic [7:0] S_addr_b;
  logic [7:0] S_addr_c;
  logic [7:0] S_data_a;
  logic [7:0] S_data_b;
  logic [7:0] S_data_c;
  logic       ks_valid;
  logic       ks_ready;
  logic [7:0] ks_data;

  modport master (
    output key_addr, S_swap, S_addr_a, S_addr_b, S_addr_c, ks_valid, ks_data,
    input  key_byte, S_data_a, S_data_b, S_data_c, ks_ready
  );

  modport slave (
    input  key_addr, S_swap, S_addr_a, S_addr_b, S_addr_c, ks_valid, ks_data,
    output key_byte, S_data_a, S_data_b, S_data_c, ks_ready
  );
endinterface

// File: rtl/rc4_ctrl.sv
// RC4 controller: drives an external swap-capable S-memory through key schedule,
// optional discard of leading bytes, then a one-byte-per-cycle keystream.
module rc4_ctrl #(
  parameter int KEY_LEN = 16,
  parameter int DROP_N  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       keyed,
  output logic [1:0] o_state,
  rc4_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KSA  = 2'd1,
    DROP = 2'd2,
    PRGA = 2'd3
  } state_t;

  localparam logic [7:0]  K_LAST = 8'(KEY_LEN - 1);
  localparam logic [15:0] D_INIT = 16'(DROP_N);

  state_t      r_state;
  logic [7:0]  r_i;
  logic [7:0]  r_j;
  logic [7:0]  r_k;
  logic [15:0] r_d;
  logic        r_keyed;
  logic        r_ks_valid;
  logic [7:0]  r_ks_data;

  logic       w_ksa;
  logic       w_gen;
  logic       w_step;
  logic [7:0] w_in;
  logic [7:0] w_jn;
  logic [7:0] w_addr_a;
  logic [7:0] w_addr_b;
  logic [7:0] w_addr_c;
  logic [7:0] w_ks;

  // Kept as separate assigns: the S-memory read path loops back through the
  // addresses, so each stage is its own combinational node.
  assign w_ksa    = (r_state == KSA);
  assign w_gen    = (r_state == DROP) || (r_state == PRGA);
  assign w_in     = r_i + 8'd1;
  assign w_addr_a = w_ksa ? r_i : (w_gen ? w_in : 8'd0);
  assign w_jn     = w_ksa ? (r_j + bus.S_data_a + bus.key_byte) : (r_j + bus.S_data_a);
  assign w_addr_b = (w_ksa || w_gen) ? w_jn : 8'd0;
  assign w_addr_c = w_gen ? (bus.S_data_a + bus.S_data_b) : 8'd0;
  assign w_step   = w_ksa || (r_state == DROP) ||
                    ((r_state == PRGA) && (!r_ks_valid || bus.ks_ready));

  // Post-swap value of S[t]; also correct when a==b since both reads then match.
  assign w_ks = (w_addr_c == w_addr_a) ? bus.S_data_b :
                (w_addr_c == w_addr_b) ? bus.S_data_a : bus.S_data_c;

  assign bus.S_swap   = w_step && rst_n;
  assign bus.S_addr_a = w_addr_a;
  assign bus.S_addr_b = w_addr_b;
  assign bus.S_addr_c = w_addr_c;
  assign bus.key_addr = r_k;
  assign bus.ks_valid = r_ks_valid;
  assign bus.ks_data  = r_ks_data;
  assign busy         = w_ksa || (r_state == DROP);
  assign keyed        = r_keyed;
  assign o_state      = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_i        <= 8'd0;
      r_j        <= 8'd0;
      r_k        <= 8'd0;
      r_d        <= D_INIT;
      r_keyed    <= 1'b0;
      r_ks_valid <= 1'b0;
      r_ks_data  <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && !r_keyed) begin
            r_state <= KSA;
            r_i     <= 8'd0;
            r_j     <= 8'd0;
            r_k     <= 8'd0;
          end
        end
        KSA: begin
          r_i <= w_in;
          r_j <= w_jn;
          r_k <= (r_k == K_LAST) ? 8'd0 : r_k + 8'd1;
          if (r_i == 8'hFF) begin
            r_keyed <= 1'b1;
            r_i     <= 8'd0;
            r_j     <= 8'd0;
            r_d     <= D_INIT;
            r_state <= (DROP_N > 0) ? DROP : PRGA;
          end
        end
        DROP: begin
          r_i <= w_in;
          r_j <= w_jn;
          r_d <= r_d - 16'd1;
          if (r_d == 16'd1) r_state <= PRGA;
        end
        default: begin
          if (w_step) begin
            r_i        <= w_in;
            r_j        <= w_jn;
            r_ks_data  <= w_ks;
            r_ks_valid <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
